pulse_gen: RTL and testbench
============================

Name: pulse_gen

Overview:
Trigger-driven pulse-train generator for the OTDR transmit path. On a rising edge of pulse_trigger it emits pulse_n laser-drive pulses, each pulse_width clocks high and separated by pulse_width clocks low. It sits between the acquisition controller and the laser driver. Triggers are blocked while the acquisition engine reports acq_busy.

Parameters:
CFG_W, 8, bit width of pulse_width and pulse_n, and of the internal width/count counters.

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset_async  input  1  asynchronous, active-low reset; asserting it clears all state immediately.
pulse_trigger  input  1  start request; only a rising edge is significant.
acq_busy  input  1  acquisition engine busy; high blocks new starts.
pulse_width  input  CFG_W  high time and low gap per pulse, in clocks.
pulse_n  input  CFG_W  number of pulses per train.
pulse_out  output  1  registered pulse output.

Behaviour:
- Reset (reset_async=0): pulse_out=0, state=IDLE, counters=0, trigger history register=0.
- Edge detect: trig_d is pulse_trigger registered once. start = pulse_trigger & ~trig_d & ~acq_busy & (state==IDLE) & (pulse_width!=0) & (pulse_n!=0).
- Configuration is latched at start. pulse_width and pulse_n changes during a train have no effect until the next start.
- FSM states and transitions:
  - IDLE: on start, go to HIGH. At that same clock edge pulse_out<=1, width_cnt<=W-1, pulse_cnt<=N-1. Latency: pulse_out rises at the first edge that samples the trigger high.
  - HIGH: pulse_out=1. If width_cnt!=0, decrement it. At width_cnt==0: if pulse_cnt==0, go to IDLE and set pulse_out<=0. Otherwise go to LOW, set width_cnt<=W-1 and pulse_out<=0.
  - LOW: pulse_out=0. If width_cnt!=0, decrement it. At width_cnt==0: go to HIGH, set width_cnt<=W-1, pulse_cnt<=pulse_cnt-1 and pulse_out<=1.
- Each pulse is exactly W clocks high and each gap exactly W clocks low. There is no trailing gap after the last pulse. Total train length = (2N-1)*W clocks.
- pulse_width=0 or pulse_n=0: no pulse; FSM stays in IDLE.
- W=1: single-cycle pulses with single-cycle gaps. W=255 and N=255 are legal; counters never wrap.
- Trigger edges during a train are ignored and not queued. A trigger held high across the end of a train does not retrigger; a new rising edge is required.
- acq_busy only gates start. If acq_busy rises mid-train, the train completes normally.
- A trigger rising edge that coincides with acq_busy=1 is discarded, even if acq_busy falls later while the trigger is still high.
- Reset mid-train: pulse_out drops asynchronously and the FSM returns to IDLE.

Optional Feature:
PULSE_GEN_TRIG_SYNC_EN
- Defined: pulse_trigger passes through a 2-flop synchronizer (reset to 0) before edge detection. Start latency grows by 2 clocks. acq_busy is sampled unsynchronized, in the same cycle as the synchronized edge.
- Undefined: pulse_trigger feeds the edge detector directly; latency is as stated in Behaviour.

Decomposition:
- Package pulse_gen_pkg holds: the CFG_W default constant; the state enum typedef {IDLE, HIGH, LOW} (2-bit encoding); a counter typedef logic [CFG_W-1:0].
- One natural sub-module: pulse_gen_edge_det. It contains the optional synchronizer plus the rising-edge detector and outputs a one-cycle rise strobe.
- The FSM and counters stay in pulse_gen.

Test Plan:
- Reset held low, then released; trigger 0 -> pulse_out stays 0, FSM in IDLE.
- W=10, N=5, trigger high for one clock, acq_busy=0 -> 5 pulses of 10 high clocks each, 4 gaps of 10 low clocks, train length 90 clocks, then IDLE.
- acq_busy=1 during a trigger rising edge (W=10, N=5) -> no pulses. Repeat with acq_busy=0 -> full train.
- Second rising edge at clock 20 of a train, then pulse_width changed to 3 mid-train -> train unchanged at W=10, N=5; the second edge produces no extra train.
- Edge cases: W=0 or N=0 -> no output. W=1, N=3 -> pattern 1,0,1,0,1, then 0.
- reset_async pulled low at clock 35 of a W=10, N=5 train -> pulse_out 0 immediately. After release, a new trigger starts a full fresh train.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the OTDR transmit pulse-train generator.
// Holds the default configuration width, the FSM state encoding and the counter type.
package pulse_gen_pkg;

    localparam int CFG_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef logic [CFG_W_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/pulse_gen_edge_det.sv
// Rising-edge detector for pulse_trigger, emitting a one-cycle rise strobe.
// Build option PULSE_GEN_TRIG_SYNC_EN inserts a 2-flop synchronizer ahead of the detector.
module pulse_gen_edge_det (
    input  logic clock,
    input  logic reset_async,
    input  logic pulse_trigger,
    output logic rise
);

    logic trig_s;
    logic trig_d;

`ifdef PULSE_GEN_TRIG_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock or negedge reset_async) begin
        if (!reset_async) begin
            sync_q <= 2'b00;
        end else begin
            // NOTE: non-blocking so both stages sample the pre-edge values and act as a real shift chain.
            sync_q <= {sync_q[0], pulse_trigger};
        end
    end

    assign trig_s = sync_q[1];
`else
    assign trig_s = pulse_trigger;
`endif

    always_ff @(posedge clock or negedge reset_async) begin
        if (!reset_async) begin
            trig_d <= 1'b0;
        end else begin
            trig_d <= trig_s;
        end
    end

    // Combinational so an unsynchronized trigger starts the train on the first edge that sees it high.
    assign rise = trig_s & ~trig_d;

endmodule

// File: rtl/pulse_gen.sv
// Trigger-driven pulse-train generator: N pulses of W clocks high separated by W clocks low.
// Optional build macro PULSE_GEN_TRIG_SYNC_EN synchronizes pulse_trigger (see pulse_gen_edge_det).
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CFG_W = CFG_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_async,
    input  logic             pulse_trigger,
    input  logic             acq_busy,
    input  logic [CFG_W-1:0] pulse_width,
    input  logic [CFG_W-1:0] pulse_n,
    output logic             pulse_out
);

    localparam logic [CFG_W-1:0] ONE = CFG_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [CFG_W-1:0] width_cnt;
    logic [CFG_W-1:0] width_cnt_nx;
    logic [CFG_W-1:0] pulse_cnt;
    logic [CFG_W-1:0] pulse_cnt_nx;
    logic [CFG_W-1:0] width_lat;
    logic [CFG_W-1:0] width_lat_nx;
    logic             pulse_nx;
    logic             rise;
    logic             start;
    logic             width_done;
    logic             last_pulse;

    pulse_gen_edge_det u_edge_det (
        .clock         (clock),
        .reset_async   (reset_async),
        .pulse_trigger (pulse_trigger),
        .rise          (rise)
    );

    assign start = rise & ~acq_busy & (state == IDLE)
                 & (pulse_width != '0) & (pulse_n != '0);

    assign width_done = (width_cnt == '0);
    assign last_pulse = (pulse_cnt == '0);

    // State register: FSM state, counters, latched width and the registered output.
    always_ff @(posedge clock or negedge reset_async) begin
        if (!reset_async) begin
            state     <= IDLE;
            width_cnt <= '0;
            pulse_cnt <= '0;
            width_lat <= '0;
            pulse_out <= 1'b0;
        end else begin
            state     <= state_nx;
            width_cnt <= width_cnt_nx;
            pulse_cnt <= pulse_cnt_nx;
            width_lat <= width_lat_nx;
            pulse_out <= pulse_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = HIGH;
            HIGH: if (width_done) state_nx = last_pulse ? IDLE : LOW;
            LOW:  if (width_done) state_nx = HIGH;
            default: state_nx = IDLE;
        endcase
    end

    // Counter updates and next output value; pulse_out simply mirrors the HIGH state one edge ahead.
    always_comb begin
        width_cnt_nx = width_cnt;
        pulse_cnt_nx = pulse_cnt;
        width_lat_nx = width_lat;
        pulse_nx     = (state_nx == HIGH);
        unique case (state)
            IDLE: begin
                if (start) begin
                    width_lat_nx = pulse_width;
                    width_cnt_nx = pulse_width - ONE;
                    pulse_cnt_nx = pulse_n - ONE;
                end
            end
            HIGH: begin
                if (!width_done) begin
                    width_cnt_nx = width_cnt - ONE;
                end else if (!last_pulse) begin
                    width_cnt_nx = width_lat - ONE;
                end
            end
            LOW: begin
                if (!width_done) begin
                    width_cnt_nx = width_cnt - ONE;
                end else begin
                    width_cnt_nx = width_lat - ONE;
                    pulse_cnt_nx = pulse_cnt - ONE;
                end
            end
            default: begin
                width_cnt_nx = '0;
                pulse_cnt_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen; expected waveforms come from a closed-form train model.
// Honors PULSE_GEN_TRIG_SYNC_EN by shifting the expected start by two clocks.
module tb_pulse_gen;
    import pulse_gen_pkg::*;

`ifdef PULSE_GEN_TRIG_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clock;
    logic       reset_async;
    logic       pulse_trigger;
    logic       acq_busy;
    logic [7:0] pulse_width;
    logic [7:0] pulse_n;
    logic       pulse_out;

    int n_cmp = 0;
    int n_err = 0;

    pulse_gen #(.CFG_W(8)) dut (
        .clock         (clock),
        .reset_async   (reset_async),
        .pulse_trigger (pulse_trigger),
        .acq_busy      (acq_busy),
        .pulse_width   (pulse_width),
        .pulse_n       (pulse_n),
        .pulse_out     (pulse_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // k = clocks since the first edge that can start the train (0 = first high sample).
    function automatic logic exp_bit(int k, int w, int n);
        if (k < 0 || w == 0 || n == 0) return 1'b0;
        if (k >= (2 * n - 1) * w) return 1'b0;
        return ((k / w) % 2) == 0;
    endfunction

    task automatic test_reset();
        reset_async = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (pulse_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: pulse_out=%b expected 0", pulse_out);
        end
        n_cmp++;
        if (dut.state !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: state=%0d expected %0d", dut.state, IDLE);
        end
        reset_async = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_cmp++;
            if (pulse_out !== 1'b0) begin
                n_err++;
                $display("FAIL reset_release cycle %0d: pulse_out=%b expected 0", i, pulse_out);
            end
        end
    endtask

    task automatic test_train();
        int highs;
        highs = 0;
        pulse_width = 8'd10;
        pulse_n     = 8'd5;
        pulse_trigger = 1'b1;
        for (int i = 0; i < 100 + LAT; i++) begin
            @(negedge clock);
            if (i == 0) pulse_trigger = 1'b0;
            if (pulse_out === 1'b1) highs++;
            n_cmp++;
            if (pulse_out !== exp_bit(i - LAT, 10, 5)) begin
                n_err++;
                $display("FAIL train_w10_n5 cycle %0d: pulse_out=%b expected %b",
                         i - LAT, pulse_out, exp_bit(i - LAT, 10, 5));
            end
        end
        n_cmp++;
        if (highs != 50) begin
            n_err++;
            $display("FAIL train_high_clocks: got %0d expected 50", highs);
        end
        n_cmp++;
        if (dut.state !== IDLE) begin
            n_err++;
            $display("FAIL train_end_state: state=%0d expected %0d", dut.state, IDLE);
        end
    endtask

    task automatic test_busy();
        pulse_width = 8'd10;
        pulse_n     = 8'd5;
        acq_busy    = 1'b1;
        pulse_trigger = 1'b1;
        repeat (3) @(negedge clock);
        acq_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_cmp++;
            if (pulse_out !== 1'b0) begin
                n_err++;
                $display("FAIL busy_discard cycle %0d: pulse_out=%b expected 0", i, pulse_out);
            end
        end
        pulse_trigger = 1'b0;
        repeat (3) @(negedge clock);
        pulse_trigger = 1'b1;
        for (int i = 0; i < 95 + LAT; i++) begin
            @(negedge clock);
            if (i == 0) pulse_trigger = 1'b0;
            if (i == 30) acq_busy = 1'b1;
            n_cmp++;
            if (pulse_out !== exp_bit(i - LAT, 10, 5)) begin
                n_err++;
                $display("FAIL busy_midtrain cycle %0d: pulse_out=%b expected %b",
                         i - LAT, pulse_out, exp_bit(i - LAT, 10, 5));
            end
        end
        acq_busy = 1'b0;
    endtask

    task automatic test_retrigger();
        pulse_width = 8'd10;
        pulse_n     = 8'd5;
        pulse_trigger = 1'b1;
        for (int i = 0; i < 120 + LAT; i++) begin
            @(negedge clock);
            if (i == 0) pulse_trigger = 1'b0;
            if (i == 19 + LAT) pulse_trigger = 1'b1;
            if (i == 22 + LAT) pulse_trigger = 1'b0;
            if (i == 25 + LAT) pulse_width = 8'd3;
            n_cmp++;
            if (pulse_out !== exp_bit(i - LAT, 10, 5)) begin
                n_err++;
                $display("FAIL retrigger cycle %0d: pulse_out=%b expected %b",
                         i - LAT, pulse_out, exp_bit(i - LAT, 10, 5));
            end
        end
        pulse_width = 8'd10;
    endtask

    task automatic test_zero_cfg();
        for (int c = 0; c < 2; c++) begin
            pulse_width = (c == 0) ? 8'd0 : 8'd10;
            pulse_n     = (c == 0) ? 8'd5 : 8'd0;
            pulse_trigger = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                n_cmp++;
                if (pulse_out !== 1'b0) begin
                    n_err++;
                    $display("FAIL zero_cfg_%0d cycle %0d: pulse_out=%b expected 0", c, i, pulse_out);
                end
            end
            n_cmp++;
            if (dut.state !== IDLE) begin
                n_err++;
                $display("FAIL zero_cfg_%0d_state: state=%0d expected %0d", c, dut.state, IDLE);
            end
            pulse_trigger = 1'b0;
            repeat (3) @(negedge clock);
        end
    endtask

    // Trigger is held high across the end of the train; no retrigger may follow.
    task automatic test_w1();
        logic exp_pat [5];
        exp_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        pulse_width = 8'd1;
        pulse_n     = 8'd3;
        pulse_trigger = 1'b1;
        for (int i = 0; i < 15 + LAT; i++) begin
            logic e;
            @(negedge clock);
            e = (i - LAT >= 0 && i - LAT < 5) ? exp_pat[i - LAT] : 1'b0;
            n_cmp++;
            if (pulse_out !== e) begin
                n_err++;
                $display("FAIL w1_n3 cycle %0d: pulse_out=%b expected %b", i - LAT, pulse_out, e);
            end
        end
        pulse_trigger = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        pulse_width = 8'd10;
        pulse_n     = 8'd5;
        for (int r = 0; r < 2; r++) begin
            int cut;
            cut = (r == 0) ? 35 : 5;
            pulse_trigger = 1'b1;
            for (int i = 0; i <= cut + LAT; i++) begin
                @(negedge clock);
                if (i == 0) pulse_trigger = 1'b0;
                n_cmp++;
                if (pulse_out !== exp_bit(i - LAT, 10, 5)) begin
                    n_err++;
                    $display("FAIL pre_reset_%0d cycle %0d: pulse_out=%b expected %b",
                             cut, i - LAT, pulse_out, exp_bit(i - LAT, 10, 5));
                end
            end
            reset_async = 1'b0;
            #1;
            n_cmp++;
            if (pulse_out !== 1'b0) begin
                n_err++;
                $display("FAIL async_reset_%0d: pulse_out=%b expected 0", cut, pulse_out);
            end
            n_cmp++;
            if (dut.state !== IDLE) begin
                n_err++;
                $display("FAIL async_reset_%0d_state: state=%0d expected %0d", cut, dut.state, IDLE);
            end
            @(negedge clock);
            reset_async = 1'b1;
            repeat (2) @(negedge clock);
        end
        pulse_trigger = 1'b1;
        for (int i = 0; i < 95 + LAT; i++) begin
            @(negedge clock);
            if (i == 0) pulse_trigger = 1'b0;
            n_cmp++;
            if (pulse_out !== exp_bit(i - LAT, 10, 5)) begin
                n_err++;
                $display("FAIL post_reset_train cycle %0d: pulse_out=%b expected %b",
                         i - LAT, pulse_out, exp_bit(i - LAT, 10, 5));
            end
        end
    endtask

    initial begin
        reset_async   = 1'b0;
        pulse_trigger = 1'b0;
        acq_busy      = 1'b0;
        pulse_width   = 8'd10;
        pulse_n       = 8'd5;
        test_reset();
        test_train();
        test_busy();
        test_retrigger();
        test_zero_cfg();
        test_w1();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
